// File: rtl/cprv_lsu_mem_if_if.sv
// Bundle of the LSU request/response handshakes and the data-memory port.
//
// Handshake rule (both req_* and resp_*): a transfer happens on the posedge
// where valid & ready are both 1. The sender keeps valid and its payload
// stable until that edge. The receiver may drive ready independently of
// valid.
//
// The slave modport is the LSU. The master modport is its environment:
// the pipeline that issues requests and the memory that returns mem_rdata.
interface cprv_lsu_mem_if_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  mem_w_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_w_en, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_w_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cprv_lsu_mem_if.sv
// RV64 load/store unit front end for a single-port 64-bit synchronous memory.
// One request is in flight at a time. Loads are aligned and extended.
// Sub-word stores use read-modify-write, because the memory only writes
// whole 64-bit words.
module cprv_lsu_mem_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cprv_lsu_mem_if_if.slave      bus,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_RSP  = 3'd2,
        S_RMW_RD  = 3'd3,
        S_RMW_MRG = 3'd4,
        S_WR      = 3'd5,
        S_RSP     = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t                state;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  accept;
    logic                  req_illegal;
    logic                  req_misal;
    logic [5:0]            lane_shift;
    logic [DATA_WIDTH-1:0] rd_shifted;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [DATA_WIDTH-1:0] size_mask;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;

    assign dbg_state = state;
    assign accept    = bus.req_valid & bus.req_ready;

    // Classify the incoming request: illegal encoding or misaligned address.
    always_comb begin
        req_illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'd7);
        case (bus.req_funct3[1:0])
            2'd1:    req_misal = bus.req_addr[0];
            2'd2:    req_misal = (bus.req_addr[1:0] != 2'd0);
            2'd3:    req_misal = (bus.req_addr[2:0] != 3'd0);
            default: req_misal = 1'b0;
        endcase
    end

    // Lane alignment, load extension and store merge for the latched request.
    always_comb begin
        lane_shift = {addr_q[2:0], 3'b000};
        rd_shifted = bus.mem_rdata >> lane_shift;
        case (funct3_q)
            3'd0:    ld_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            3'd1:    ld_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'd2:    ld_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'd3:    ld_ext = rd_shifted;
            3'd4:    ld_ext = {56'd0, rd_shifted[7:0]};
            3'd5:    ld_ext = {48'd0, rd_shifted[15:0]};
            3'd6:    ld_ext = {32'd0, rd_shifted[31:0]};
            default: ld_ext = '0;
        endcase
        case (funct3_q[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
        lane_mask = size_mask << lane_shift;
        merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    end

    // Control FSM. All bus outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            we_q           <= 1'b0;
            funct3_q       <= 3'd0;
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_w_en   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            // The write strobe is a single-cycle pulse; only WR entry raises it.
            bus.mem_w_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q          <= bus.req_we;
                        funct3_q      <= bus.req_funct3;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (req_illegal || req_misal) begin
                            state          <= S_ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            bus.mem_addr <= {bus.req_addr[ADDR_WIDTH-1:3], 3'b000};
                            if (!bus.req_we) begin
                                state <= S_LD_RD;
                            end else if (bus.req_funct3 == 3'd3) begin
                                // Full-word store needs no read-back.
                                state         <= S_WR;
                                bus.mem_wdata <= bus.req_wdata;
                                bus.mem_w_en  <= 1'b1;
                            end else begin
                                state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LD_RD: begin
                    bus.mem_addr <= {addr_q[ADDR_WIDTH-1:3], 3'b000};
                    state        <= S_LD_RSP;
                end
                S_LD_RSP: begin
                    bus.resp_rdata <= we_q ? '0 : ld_ext;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= S_RSP;
                end
                S_RMW_RD: begin
                    bus.mem_addr <= {addr_q[ADDR_WIDTH-1:3], 3'b000};
                    state        <= S_RMW_MRG;
                end
                S_RMW_MRG: begin
                    bus.mem_wdata <= merged;
                    bus.mem_w_en  <= 1'b1;
                    state         <= S_WR;
                end
                S_WR: begin
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= S_RSP;
                end
                S_RSP, S_ERR: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= '0;
                        bus.req_ready  <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cprv_lsu_mem_if.sv
// Self-checking bench for cprv_lsu_mem_if: directed cases plus random traffic,
// checked against a byte-array reference memory.
module tb_cprv_lsu_mem_if;

    localparam int AW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cprv_lsu_mem_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) bus ();
    logic [2:0] dbg_state;

    cprv_lsu_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Synchronous single-port memory: registered read, full-word write.
    logic [63:0] mem_words [16];
    always @(posedge clk) begin
        if (bus.mem_w_en) mem_words[bus.mem_addr[6:3]] <= bus.mem_wdata;
        bus.mem_rdata <= mem_words[bus.mem_addr[6:3]];
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [128];

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [6:0] addr);
        if (we && f3 >= 3'd4) return 1'b1;
        if (!we && f3 == 3'd7) return 1'b1;
        return (int'(addr) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [6:0] addr);
        int n = nbytes(f3);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        if (f3 < 3'd3 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    function automatic logic [63:0] ref_word(input int addr);
        int base = addr & 'h78;
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
        return v;
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [6:0] addr, input logic [63:0] wd);
        for (int i = 0; i < nbytes(f3); i++) ref_mem[int'(addr) + i] = wd[8 * i +: 8];
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                          input logic [63:0] wd, input int hold,
                          output logic [63:0] got, output int wait_cyc);
        logic        exp_err;
        logic [63:0] exp_rd;
        logic [63:0] exp_wr;
        int          exp_lat, exp_wr_cnt;
        int          lat, wr_cnt, wr_idx;
        logic [63:0] wr_a, wr_d;
        logic        busy_rdy, stable;

        exp_err    = ref_err(we, f3, addr);
        exp_lat    = exp_err ? 1 : (!we ? 3 : (f3 == 3'd3 ? 2 : 4));
        exp_rd     = (exp_err || we) ? 64'd0 : ref_load(f3, addr);
        exp_wr_cnt = (!exp_err && we) ? 1 : 0;
        exp_wr     = '0;
        if (exp_wr_cnt == 1) begin
            ref_store(f3, addr, wd);
            exp_wr = ref_word(int'(addr));
        end

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        wait_cyc = 0;
        while (bus.req_ready !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("accept_timeout", 64'(wait_cyc < 20), 64'd1);
        @(posedge clk);

        lat = 0; wr_cnt = 0; wr_idx = 0; wr_a = '0; wr_d = '0; busy_rdy = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) bus.req_valid = 1'b0;
            if (bus.mem_w_en === 1'b1) begin
                wr_cnt++;
                wr_idx = n;
                wr_a   = 64'(bus.mem_addr);
                wr_d   = bus.mem_wdata;
            end
            if (bus.req_ready !== 1'b0) busy_rdy = 1'b1;
            if (bus.resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        check("latency",    64'(lat), 64'(exp_lat));
        check("resp_err",   64'(bus.resp_err), 64'(exp_err));
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("ready_busy", 64'(busy_rdy), 64'd0);
        check("wr_count",   64'(wr_cnt), 64'(exp_wr_cnt));
        if (exp_wr_cnt == 1) begin
            check("wr_cycle", 64'(wr_idx), 64'(exp_lat - 1));
            check("wr_addr",  wr_a, 64'(int'(addr) & 'h78));
            check("wr_data",  wr_d, exp_wr);
        end
        got = bus.resp_rdata;

        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== got || bus.resp_err !== exp_err ||
                bus.req_ready !== 1'b0 || bus.mem_w_en !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 64'(stable), 64'd1);

        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("post_hs_req_ready",  64'(bus.req_ready), 64'd1);
        check("post_hs_resp_valid", 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(bus.req_ready), 64'd1);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_resp_err"},   64'(bus.resp_err), 64'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
        check({tag, "_mem_w_en"},   64'(bus.mem_w_en), 64'd0);
        check({tag, "_mem_addr"},   64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_wdata"},  bus.mem_wdata, 64'd0);
    endtask

    // Watchdog: every wait is bounded, this only guards against a stuck clock.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] got;
        int          wc;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [6:0]  r_addr;

        for (int w = 0; w < 16; w++) mem_words[w] = {$urandom, $urandom};
        mem_words[1] = 64'hF0E1_D2C3_B4A5_9687;
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 8; b++) ref_mem[w * 8 + b] = mem_words[w][8 * b +: 8];

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Loads from the preloaded word at 0x08
        do_req(1'b0, 3'd0, 7'h0F, 64'd0, 0, got, wc);
        check("lb_0f", got, 64'hFFFF_FFFF_FFFF_FFF0);
        do_req(1'b0, 3'd4, 7'h0F, 64'd0, 0, got, wc);
        check("lbu_0f", got, 64'h0000_0000_0000_00F0);
        do_req(1'b0, 3'd1, 7'h0A, 64'd0, 0, got, wc);
        check("lh_0a", got, 64'hFFFF_FFFF_FFFF_B4A5);
        do_req(1'b0, 3'd6, 7'h0C, 64'd0, 0, got, wc);
        check("lwu_0c", got, 64'h0000_0000_F0E1_D2C3);

        // Sub-word store then read-back
        do_req(1'b1, 3'd0, 7'h0A, 64'h55, 0, got, wc);
        do_req(1'b0, 3'd3, 7'h08, 64'd0, 0, got, wc);
        check("ld_08_after_sb", got, 64'hF0E1_D2C3_B455_9687);

        // Full-word store then read-back
        do_req(1'b1, 3'd3, 7'h10, 64'h0123_4567_89AB_CDEF, 0, got, wc);
        do_req(1'b0, 3'd3, 7'h10, 64'd0, 0, got, wc);
        check("ld_10_after_sd", got, 64'h0123_4567_89AB_CDEF);

        // Error responses
        do_req(1'b0, 3'd2, 7'h0A, 64'd0, 0, got, wc);
        do_req(1'b1, 3'd5, 7'h08, 64'hDEAD, 0, got, wc);

        // Back-pressure on the response, then a back-to-back request
        do_req(1'b0, 3'd3, 7'h08, 64'd0, 3, got, wc);
        do_req(1'b0, 3'd4, 7'h08, 64'd0, 0, got, wc);
        check("b2b_accept_wait", 64'(wc), 64'd0);

        // Reset asserted while the SB 0x08 merge is in progress
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 7'h08;
        bus.req_wdata  = 64'hAA;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        check("midrst_mem_unchanged", mem_words[1], ref_word(8));
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        do_req(1'b0, 3'd3, 7'h08, 64'd0, 0, got, wc);

        // Random traffic
        repeat (80) begin
            r_we = 1'(($urandom_range(0, 1)));
            r_f3 = 3'($urandom_range(0, 7));
            if (r_we && $urandom_range(0, 4) != 0) r_f3[2] = 1'b0;
            r_addr = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~7'(nbytes(r_f3) - 1);
            do_req(r_we, r_f3, r_addr, {$urandom, $urandom}, $urandom_range(0, 2), got, wc);
        end

        // Whole-memory consistency
        for (int w = 0; w < 16; w++) check("final_mem", mem_words[w], ref_word(w * 8));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
